// File: rtl/spike_tx_pkg.sv
// Shared constants and FSM state type for the spike address transmitter.
package spike_tx_pkg;

   localparam int DEF_NUM_NEURONS = 10;
   localparam int DEF_ADDR_W      = 12;
   localparam int DEF_BASE_ADDR   = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      FIN  = 2'd2
   } spike_tx_state_t;

   // Index width for an n-entry vector, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spike_prio_enc.sv
// Lowest-set-bit priority encoder: idx is the smallest set position of vec.
module spike_prio_enc #(
   parameter int N     = 10,
   parameter int IDX_W = 4
) (
   input  logic [N-1:0]     vec,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Scanning downward lets the lowest set bit overwrite earlier hits.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = IDX_W'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spike_addr_tx.sv
// Streams one source address per fired neuron after each timestep boundary.
// Optional feature: define SPIKE_TX_COUNT_EN to add the spike_count output.
module spike_addr_tx
   import spike_tx_pkg::*;
#(
   parameter int NUM_NEURONS = DEF_NUM_NEURONS,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int BASE_ADDR   = DEF_BASE_ADDR
) (
   input  logic                   CLK_Spike,
   input  logic                   RST_n,
   input  logic                   clear,
   input  logic [NUM_NEURONS-1:0] spikes_in,
   output logic [ADDR_W-1:0]      source_address,
   output logic                   addr_valid,
   input  logic                   addr_ready,
   output logic                   busy,
   output logic                   done,
   output logic                   overrun
`ifdef SPIKE_TX_COUNT_EN
   ,
   output logic [$clog2(NUM_NEURONS+1)-1:0] spike_count
`endif
);

   localparam int IDX_W = idx_w(NUM_NEURONS);
   localparam logic [ADDR_W-1:0]      BASE = ADDR_W'(BASE_ADDR);
   localparam logic [NUM_NEURONS-1:0] ONE  = NUM_NEURONS'(1);

   spike_tx_state_t        state;
   spike_tx_state_t        next_state;
   logic [NUM_NEURONS-1:0] pending;
   logic [NUM_NEURONS-1:0] next_pending;
   logic [IDX_W-1:0]       cur_idx;
   logic [IDX_W-1:0]       enc_idx;
   logic                   enc_any;
   logic                   xfer;

   assign xfer = addr_valid & addr_ready;

   // Encoding the next pending set lets the following address be registered
   // in the same edge as the transfer, giving one address per cycle.
   always_comb begin
      next_pending = pending;
      if (clear) begin
         next_pending = spikes_in;
      end else if (xfer) begin
         next_pending = pending & ~(ONE << cur_idx);
      end
   end

   spike_prio_enc #(
      .N     (NUM_NEURONS),
      .IDX_W (IDX_W)
   ) u_prio_enc (
      .vec (next_pending),
      .idx (enc_idx),
      .any (enc_any)
   );

   always_comb begin
      next_state = state;
      case (state)
         IDLE, FIN: begin
            if (clear) begin
               next_state = (|spikes_in) ? SEND : FIN;
            end else begin
               next_state = IDLE;
            end
         end
         SEND: begin
            next_state = enc_any ? SEND : FIN;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK_Spike or negedge RST_n) begin
      if (!RST_n) begin
         state          <= IDLE;
         pending        <= '0;
         cur_idx        <= '0;
         source_address <= '0;
         addr_valid     <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         overrun        <= 1'b0;
      end else begin
         state      <= next_state;
         pending    <= next_pending;
         addr_valid <= (next_state == SEND);
         busy       <= (next_state == SEND);
         done       <= (next_state == FIN);
         if (state == SEND && clear) begin
            overrun <= 1'b1;
         end
         // Address only moves when a new bit is selected, so it holds on stall.
         if (enc_any) begin
            cur_idx        <= enc_idx;
            source_address <= BASE + ADDR_W'(enc_idx);
         end
      end
   end

`ifdef SPIKE_TX_COUNT_EN
   localparam int CNT_W = $clog2(NUM_NEURONS + 1);

   // A transfer coincident with clear belongs to the old timestep.
   always_ff @(posedge CLK_Spike or negedge RST_n) begin
      if (!RST_n) begin
         spike_count <= '0;
      end else if (clear) begin
         spike_count <= '0;
      end else if (xfer) begin
         spike_count <= spike_count + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_spike_addr_tx.sv
// Self-checking bench for spike_addr_tx: vector table, directed corners, random vs queue model.
module tb_spike_addr_tx;

   localparam int N    = 10;
   localparam int AW   = 12;
   localparam int BASE = 12;

   logic          CLK_Spike;
   logic          RST_n;
   logic          clear;
   logic [N-1:0]  spikes_in;
   logic [AW-1:0] source_address;
   logic          addr_valid;
   logic          addr_ready;
   logic          busy;
   logic          done;
   logic          overrun;
`ifdef SPIKE_TX_COUNT_EN
   logic [3:0]    spike_count;
`endif

   spike_addr_tx #(
      .NUM_NEURONS (N),
      .ADDR_W      (AW),
      .BASE_ADDR   (BASE)
   ) dut (
      .CLK_Spike      (CLK_Spike),
      .RST_n          (RST_n),
      .clear          (clear),
      .spikes_in      (spikes_in),
      .source_address (source_address),
      .addr_valid     (addr_valid),
      .addr_ready     (addr_ready),
      .busy           (busy),
      .done           (done),
      .overrun        (overrun)
`ifdef SPIKE_TX_COUNT_EN
      ,
      .spike_count    (spike_count)
`endif
   );

   initial CLK_Spike = 1'b0;
   always #5 CLK_Spike = ~CLK_Spike;

   int checks_total  = 0;
   int checks_passed = 0;

   // Behavioural model: queue of neuron indices still owed to the consumer.
   int m_q[$];
   bit m_ovr;
   bit m_done;
   int m_cnt;

   // Outputs observed during the most recent tick.
   logic          cap_valid;
   logic [AW-1:0] cap_addr;
   logic          cap_done;
   logic          cap_busy;
   logic          cap_ovr;
   int            cap_cnt;

   typedef struct {
      logic [N-1:0] spikes;
      int           n_addr;
      int           first_addr;
      int           last_addr;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks_total++;
      if (act !== exp) begin
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end else begin
         checks_passed++;
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_ovr  = 0;
      m_done = 0;
      m_cnt  = 0;
   endtask

   // One clock cycle: drive inputs, compare outputs with the model, advance both.
   task automatic applyStimulus(input logic c, input logic [N-1:0] s, input logic r);
      bit exp_valid;
      bit xfer;
      clear      = c;
      spikes_in  = s;
      addr_ready = r;
      exp_valid  = (m_q.size() > 0);
      cap_valid  = addr_valid;
      cap_addr   = source_address;
      cap_done   = done;
      cap_busy   = busy;
      cap_ovr    = overrun;
`ifdef SPIKE_TX_COUNT_EN
      cap_cnt    = int'(spike_count);
`else
      cap_cnt    = m_cnt;
`endif
      checkOutput(exp_valid);
      xfer = exp_valid && r;
      if (xfer) begin
         void'(m_q.pop_front());
         m_cnt++;
      end
      if (c) begin
         if (exp_valid) m_ovr = 1;
         m_q.delete();
         for (int i = 0; i < N; i++) if (s[i]) m_q.push_back(i);
         m_cnt  = 0;
         m_done = (m_q.size() == 0);
      end else begin
         m_done = xfer && (m_q.size() == 0);
      end
      @(posedge CLK_Spike);
      #1;
   endtask

   task automatic checkOutput(input bit exp_valid);
      logic [AW-1:0] exp_addr;
      check("valid", {31'd0, addr_valid}, {31'd0, exp_valid});
      check("busy", {31'd0, busy}, {31'd0, exp_valid});
      check("done", {31'd0, done}, {31'd0, m_done});
      check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
      if (exp_valid) begin
         exp_addr = AW'(BASE + m_q[0]);
         check("addr", {20'd0, source_address}, {20'd0, exp_addr});
      end
`ifdef SPIKE_TX_COUNT_EN
      check("spike_count", {28'd0, spike_count}, m_cnt);
`endif
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t vecs[5];
      vecs[0] = '{10'b0000000101, 2, 12, 14};
      vecs[1] = '{10'b1000000010, 2, 13, 21};
      vecs[2] = '{10'b1111111111, 10, 12, 21};
      vecs[3] = '{10'b0000000000, 0, 0, 0};
      vecs[4] = '{10'b0100000000, 1, 20, 20};

      RST_n      = 1'b0;
      clear      = 1'b0;
      spikes_in  = '0;
      addr_ready = 1'b0;
      model_reset();
      #2;
      check("rst_addr", {20'd0, source_address}, 32'd0);
      check("rst_valid", {31'd0, addr_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_overrun", {31'd0, overrun}, 32'd0);
      @(posedge CLK_Spike);
      #1;
      RST_n = 1'b1;
      applyStimulus(1'b0, '0, 1'b1);

      // Vector table: clear then ready held high until the done pulse.
      foreach (vecs[v]) begin
         applyStimulus(1'b1, vecs[v].spikes, 1'b1);
         for (int k = 1; k <= vecs[v].n_addr + 1; k++) begin
            applyStimulus(1'b0, '0, 1'b1);
            if (k == 1 && vecs[v].n_addr > 0)
               check("tbl_first", {20'd0, cap_addr}, vecs[v].first_addr);
            if (k == vecs[v].n_addr && vecs[v].n_addr > 0)
               check("tbl_last", {20'd0, cap_addr}, vecs[v].last_addr);
            if (k <= vecs[v].n_addr)
               check("tbl_valid", {31'd0, cap_valid}, 32'd1);
         end
         check("tbl_done", {31'd0, cap_done}, 32'd1);
         check("tbl_cnt", cap_cnt, vecs[v].n_addr);
         applyStimulus(1'b0, '0, 1'b1);
         check("tbl_done_end", {31'd0, cap_done}, 32'd0);
      end

      // Backpressure: 13 held for three stalled cycles, then 13 and 21.
      applyStimulus(1'b1, 10'b1000000010, 1'b0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, '0, 1'b0);
         check("bp_hold_addr", {20'd0, cap_addr}, 32'd13);
         check("bp_hold_valid", {31'd0, cap_valid}, 32'd1);
      end
      applyStimulus(1'b0, '0, 1'b1);
      check("bp_addr0", {20'd0, cap_addr}, 32'd13);
      applyStimulus(1'b0, '0, 1'b1);
      check("bp_addr1", {20'd0, cap_addr}, 32'd21);
      applyStimulus(1'b0, '0, 1'b1);
      check("bp_done", {31'd0, cap_done}, 32'd1);

      // Overrun: reload after three transfers while 15 is being accepted.
      applyStimulus(1'b1, 10'b1111111111, 1'b1);
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, '0, 1'b1);
      applyStimulus(1'b1, 10'b0000010000, 1'b1);
      check("ovr_pre", {31'd0, cap_ovr}, 32'd0);
      applyStimulus(1'b0, '0, 1'b1);
      check("ovr_flag", {31'd0, cap_ovr}, 32'd1);
      check("ovr_addr", {20'd0, cap_addr}, 32'd16);
      applyStimulus(1'b0, '0, 1'b1);
      check("ovr_done", {31'd0, cap_done}, 32'd1);
      applyStimulus(1'b0, '0, 1'b1);

      // Reset while an address is valid and stalled.
      applyStimulus(1'b1, 10'b1111111111, 1'b0);
      applyStimulus(1'b0, '0, 1'b0);
      check("mid_valid_before", {31'd0, cap_valid}, 32'd1);
      RST_n = 1'b0;
      #2;
      check("mid_addr", {20'd0, source_address}, 32'd0);
      check("mid_valid", {31'd0, addr_valid}, 32'd0);
      check("mid_busy", {31'd0, busy}, 32'd0);
      check("mid_done", {31'd0, done}, 32'd0);
      check("mid_overrun", {31'd0, overrun}, 32'd0);
      model_reset();
      @(posedge CLK_Spike);
      #1;
      RST_n = 1'b1;
      for (int k = 0; k < 4; k++) applyStimulus(1'b0, '0, 1'b1);

      // Random traffic checked cycle by cycle against the queue model.
      for (int k = 0; k < 600; k++) begin
         logic          c;
         logic [N-1:0]  s;
         logic          r;
         c = ($urandom_range(0, 11) == 0);
         s = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
         r = ($urandom_range(0, 3) != 0);
         applyStimulus(c, s, r);
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
